// File: rtl/cmp_run_ctrl.sv
// cmp_run_ctrl: sequences a multi-core run: hold cores in reset, run until each core fetches HALT_WORD, flush, sweep memory.
// Optional run watchdog: define CMP_RUN_WATCHDOG_EN. All buses are big-endian (bit 0 is the MSB).
module cmp_run_ctrl #(
  parameter int              NCORES         = 4,
  parameter int              IW             = 32,
  parameter logic [0:IW-1]   HALT_WORD      = '0,
  parameter int              RST_CYCLES     = 5,
  parameter int              FLUSH_CYCLES   = 5,
  parameter int              DUMP_DEPTH     = 512,
  parameter int              CW             = 32,
  parameter int              TIMEOUT_CYCLES = 100000,
  localparam int             AW             = (DUMP_DEPTH > 1) ? $clog2(DUMP_DEPTH) : 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [0:NCORES*IW-1]   inst,
  input  logic                   dump_ready,
  output logic                   core_rst,
  output logic [0:CW-1]          cycle_cnt,
  output logic [0:NCORES-1]      halted,
  output logic [0:NCORES*CW-1]   halt_cycle,
  output logic                   dump_valid,
  output logic [0:AW-1]          dump_addr,
  output logic                   done,
  output logic                   timeout
);

  // One down-counter-free phase counter is shared by HOLD and FLUSH; they never overlap.
  localparam int CNT_MAX = (RST_CYCLES > FLUSH_CYCLES) ? RST_CYCLES : FLUSH_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] RST_LAST   = CNTW'(RST_CYCLES - 1);
  localparam logic [CNTW-1:0] FLUSH_LAST = CNTW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [0:AW-1]   ADDR_LAST  = AW'(DUMP_DEPTH - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_FLUSH,
    S_DUMP,
    S_DONE
  } state_t;

  localparam state_t S_AFTER_RUN = (FLUSH_CYCLES == 0) ? S_DUMP : S_FLUSH;

  state_t                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [0:CW-1]           cyc_q, cyc_d;
  logic [0:CW-1]           cyc_inc;
  logic [0:NCORES-1]       halted_q, halted_d;
  logic [0:NCORES*CW-1]    halt_cyc_q, halt_cyc_d;
  logic [0:AW-1]           addr_q, addr_d;
  logic                    wdog_fire;

  assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CW'(1);

`ifdef CMP_RUN_WATCHDOG_EN
  localparam logic [0:CW-1] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic timeout_q;

  assign wdog_fire = (state_q == S_RUN) && (cyc_q == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      timeout_q <= 1'b0;
    end else if (wdog_fire) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign wdog_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    halted_d   = halted_q;
    halt_cyc_d = halt_cyc_q;
    addr_d     = addr_q;

    unique case (state_q)
      S_HOLD: begin
        cyc_d = '0;
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      S_RUN: begin
        cyc_d = cyc_inc;
        for (int k = 0; k < NCORES; k++) begin
          if (!halted_q[k] && (inst[k*IW +: IW] == HALT_WORD)) begin
            halted_d[k]             = 1'b1;
            halt_cyc_d[k*CW +: CW]  = cyc_q;
          end
        end
        // Halts landing on this edge count toward the all-halted test.
        if ((&halted_d) || wdog_fire) begin
          state_d = S_AFTER_RUN;
        end
      end

      S_FLUSH: begin
        cyc_d = cyc_inc;
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = S_DUMP;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      S_DUMP: begin
        if (dump_ready) begin
          if (addr_q == ADDR_LAST) begin
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end

      S_DONE: begin
      end

      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      cyc_q      <= '0;
      halted_q   <= '0;
      halt_cyc_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      halted_q   <= halted_d;
      halt_cyc_q <= halt_cyc_d;
      addr_q     <= addr_d;
    end
  end

  assign core_rst   = (state_q == S_HOLD);
  assign dump_valid = (state_q == S_DUMP);
  assign done       = (state_q == S_DONE);
  assign cycle_cnt  = cyc_q;
  assign halted     = halted_q;
  assign halt_cycle = halt_cyc_q;
  assign dump_addr  = addr_q;

endmodule

// File: tb/tb_cmp_run_ctrl.sv
// Bench for cmp_run_ctrl: directed run/flush/dump scenarios with a queue-based scoreboard
// checking dump acceptances and per-core halt events; a second instance covers FLUSH_CYCLES=0.
module tb_cmp_run_ctrl;

  localparam int NC = 4;
  localparam int IW = 32;
  localparam int CW = 32;
  localparam logic [31:0] HALT = 32'h0000_0000;

  typedef struct {
    int core;
    int cyc;
  } halt_ev_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              RESET;
  logic [0:NC*IW-1]  inst;
  logic              dump_ready;
  logic              core_rst;
  logic [0:CW-1]     cycle_cnt;
  logic [0:NC-1]     halted;
  logic [0:NC*CW-1]  halt_cycle;
  logic              dump_valid;
  logic [0:8]        dump_addr;
  logic              done;
  logic              timeout;

  logic [0:NC*IW-1]  inst2;
  logic              dump_ready2;
  logic              core_rst2;
  logic [0:CW-1]     cycle_cnt2;
  logic [0:NC-1]     halted2;
  logic [0:NC*CW-1]  halt_cycle2;
  logic              dump_valid2;
  logic [0:1]        dump_addr2;
  logic              done2;
  logic              timeout2;

  cmp_run_ctrl dut (
    .CLK(CLK), .RESET(RESET), .inst(inst), .dump_ready(dump_ready),
    .core_rst(core_rst), .cycle_cnt(cycle_cnt), .halted(halted), .halt_cycle(halt_cycle),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .done(done), .timeout(timeout)
  );

  cmp_run_ctrl #(.FLUSH_CYCLES(0), .DUMP_DEPTH(4)) dut2 (
    .CLK(CLK), .RESET(RESET), .inst(inst2), .dump_ready(dump_ready2),
    .core_rst(core_rst2), .cycle_cnt(cycle_cnt2), .halted(halted2), .halt_cycle(halt_cycle2),
    .dump_valid(dump_valid2), .dump_addr(dump_addr2), .done(done2), .timeout(timeout2)
  );

  int checks = 0;
  int errors = 0;
  int       exp_addr[$];
  halt_ev_t halt_exp[$];
  logic [0:NC-1] prev_halted = '0;
  int halt_at[NC] = '{10, 20, 20, 35};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] busy_word(input int k, input int r);
    return 32'(1000 * (k + 1) + r + 1);
  endfunction

  // Scoreboard monitor: pops expected responses whenever the DUT presents one.
  always @(negedge CLK) begin
    if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dump_extra: address %0d accepted, none expected", dump_addr);
      end else begin
        check("dump_addr", dump_addr, exp_addr.pop_front());
      end
    end
    for (int k = 0; k < NC; k++) begin
      if (halted[k] === 1'b1 && prev_halted[k] !== 1'b1) begin
        if (halt_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL halt_extra: core %0d halted, none expected", k);
        end else begin
          halt_ev_t e;
          e = halt_exp.pop_front();
          check("halt_core", k, e.core);
          check("halt_cycle", halt_cycle[k*CW +: CW], e.cyc);
        end
      end
    end
    prev_halted = halted;
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_core_rst"}, core_rst, 1'b1);
    check({tag, "_cycle_cnt"}, cycle_cnt, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_halt_cycle"}, halt_cycle, 0);
    check({tag, "_dump_valid"}, dump_valid, 1'b0);
    check({tag, "_dump_addr"}, dump_addr, 0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
  endtask

  // Reset, hold, run the halt program, flush; returns at the start of run cycle 42.
  task automatic run_to_dump();
    RESET = 1'b1;
    dump_ready = 1'b0;
    dump_ready2 = 1'b0;
    for (int k = 0; k < NC; k++) begin
      inst[k*IW +: IW]  = busy_word(k, 99);
      inst2[k*IW +: IW] = busy_word(k, 99);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    check_reset_state("reset");
    @(posedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("hold_core_rst", core_rst, 1'b1);
      check("hold_cycle_cnt", cycle_cnt, 0);
    end
    @(posedge CLK); #1;
    for (int r = 0; r <= 35; r++) begin
      for (int k = 0; k < NC; k++) begin
        // Core 0 keeps presenting HALT after its halt; those repeats must be ignored.
        inst[k*IW +: IW]  = (r == halt_at[k] || (k == 0 && r > 10)) ? HALT : busy_word(k, r);
        inst2[k*IW +: IW] = (r == 7) ? HALT : busy_word(k, r);
        if (r == halt_at[k]) halt_exp.push_back('{core: k, cyc: r});
      end
      @(negedge CLK);
      if (r == 0) begin
        check("run0_core_rst", core_rst, 1'b0);
        check("run0_cycle_cnt", cycle_cnt, 0);
        check("run0_dump_valid", dump_valid, 1'b0);
      end
      if (r == 7) check("nf_dump_valid_pre", dump_valid2, 1'b0);
      if (r == 8) begin
        check("nf_dump_valid", dump_valid2, 1'b1);
        check("nf_cycle_cnt", cycle_cnt2, 8);
        check("nf_halted", halted2, 4'b1111);
        check("nf_dump_addr", dump_addr2, 0);
      end
      @(posedge CLK); #1;
    end
    for (int k = 0; k < NC; k++) inst[k*IW +: IW] = HALT;
    for (int c = 36; c <= 40; c++) begin
      @(negedge CLK);
      check("flush_dump_valid", dump_valid, 1'b0);
      check("flush_cycle_cnt", cycle_cnt, c);
      check("flush_core_rst", core_rst, 1'b0);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    check("dump_start_valid", dump_valid, 1'b1);
    check("dump_start_cycle", cycle_cnt, 41);
    check("dump_start_addr", dump_addr, 0);
    check("dump_start_halted", halted, 4'b1111);
    @(posedge CLK); #1;
  endtask

  task automatic sweep_toggle();
    int guard = 0;
    for (int a = 0; a < 512; a++) exp_addr.push_back(a);
    while (done !== 1'b1 && guard < 3000) begin
      dump_ready = ~dump_ready;
      @(posedge CLK); #1;
      guard++;
    end
    check("sweep_within_budget", guard < 3000, 1'b1);
    dump_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("done_flag", done, 1'b1);
    check("done_dump_valid", dump_valid, 1'b0);
    check("done_core_rst", core_rst, 1'b0);
    check("done_cycle_hold", cycle_cnt, 41);
    check("done_addrs_left", exp_addr.size(), 0);
    check("done_halt_cycle", halt_cycle, {32'd10, 32'd20, 32'd20, 32'd35});
    check("done_timeout", timeout, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    dump_ready = 1'b0;
    dump_ready2 = 1'b0;
    inst = '1;
    inst2 = '1;

    run_to_dump();
    sweep_toggle();

    // Reset while dump_addr is 100.
    run_to_dump();
    dump_ready = 1'b1;
    for (int a = 0; a < 100; a++) exp_addr.push_back(a);
    repeat (100) begin
      @(posedge CLK); #1;
    end
    RESET = 1'b1;
    dump_ready = 1'b0;
    @(negedge CLK);
    check("mid_dump_addr", dump_addr, 100);
    check("mid_dump_valid", dump_valid, 1'b1);
    check("mid_dump_addrs_left", exp_addr.size(), 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_reset_state("abort");

    run_to_dump();
    sweep_toggle();

    check("halt_events_left", halt_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
